// File: rtl/seven_segment_display_controller_pkg.sv
// Shared state encodings, constants and the double-dabble step used by the
// seven-segment display controller.
package seven_segment_display_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  // All segments off, in the active-high abcdefg domain of the mapping block.
  localparam logic [6:0] C_SEG_BLANK   = 7'b0000000;
  localparam int         C_NUM_DIGITS  = 5;
  localparam int         C_CONV_CYCLES = 16;

  // One double-dabble iteration on {bcd, shift}: add 3 to every nibble >= 5,
  // then shift the whole 36-bit pair left by one.
  function automatic logic [35:0] dabble_step(input logic [19:0] bcd,
                                              input logic [15:0] shift);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < C_NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return {adj, shift} << 1;
  endfunction

endpackage

// File: rtl/bcd_seven_segment_mapping.sv
// Digit to seven-segment decode, active-high, segment order abcdefg (MSB..LSB).
// Codes A-F render as A, b, C, d, E, F for hex mode.
module bcd_seven_segment_mapping (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
  end

endmodule

// File: rtl/seven_segment_display_controller.sv
// Accepts a 16-bit word, converts it to five BCD digits (or four hex nibbles)
// and holds the decoded segment patterns until the next word completes.
module seven_segment_display_controller
  import seven_segment_display_controller_pkg::*;
#(
  parameter bit P_ACTIVE_LOW = 1'b1
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic [15:0] I_DATA,
  input  logic        I_HEX_MODE,
  input  logic        I_BLANK_LZ,
  input  logic        I_VALID,
  output logic        O_READY,
  output logic        O_DONE,
  output logic [6:0]  O_HEX0,
  output logic [6:0]  O_HEX1,
  output logic [6:0]  O_HEX2,
  output logic [6:0]  O_HEX3,
  output logic [6:0]  O_HEX4
);

  localparam logic [6:0] SEG_POL   = {7{P_ACTIVE_LOW}};
  localparam logic [6:0] SEG_RESET = C_SEG_BLANK ^ SEG_POL;
  localparam logic [3:0] CNT_LAST  = 4'(C_CONV_CYCLES - 1);

  state_t      state;
  logic [15:0] shift_q;
  logic [19:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        hex_mode_q;
  logic        blank_lz_q;
  logic        done_q;

  logic [C_NUM_DIGITS-1:0][6:0] seg_map;
  logic [C_NUM_DIGITS-1:0][6:0] seg_next;
  logic [C_NUM_DIGITS-1:0][6:0] hex_q;
  logic [C_NUM_DIGITS-1:0]      digit_zero;
  logic [C_NUM_DIGITS-1:0]      blank;

  for (genvar i = 0; i < C_NUM_DIGITS; i++) begin : g_digit
    bcd_seven_segment_mapping u_map (
      .digit (bcd_q[4*i +: 4]),
      .seg   (seg_map[i])
    );
    assign digit_zero[i] = (bcd_q[4*i +: 4] == 4'h0);
    assign seg_next[i]   = (blank[i] ? C_SEG_BLANK : seg_map[i]) ^ SEG_POL;
  end

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = C_NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & digit_zero[i];
      blank[i]   = blank_lz_q & zero_above;
    end
    blank[C_NUM_DIGITS-1] = blank[C_NUM_DIGITS-1] | hex_mode_q;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      hex_mode_q <= 1'b0;
      blank_lz_q <= 1'b0;
      done_q     <= 1'b0;
      hex_q      <= {C_NUM_DIGITS{SEG_RESET}};
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_VALID) begin
            shift_q    <= I_DATA;
            hex_mode_q <= I_HEX_MODE;
            blank_lz_q <= I_BLANK_LZ;
            cnt_q      <= '0;
            if (I_HEX_MODE) begin
              bcd_q <= {4'h0, I_DATA};
              state <= S_UPDATE;
            end else begin
              bcd_q <= '0;
              state <= S_CONVERT;
            end
          end
        end
        S_CONVERT: begin
          {bcd_q, shift_q} <= dabble_step(bcd_q, shift_q);
          cnt_q            <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) state <= S_UPDATE;
        end
        S_UPDATE: begin
          hex_q  <= seg_next;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign O_READY = (state == S_IDLE);
  assign O_DONE  = done_q;
  assign O_HEX0  = hex_q[0];
  assign O_HEX1  = hex_q[1];
  assign O_HEX2  = hex_q[2];
  assign O_HEX3  = hex_q[3];
  assign O_HEX4  = hex_q[4];

endmodule
